// File: rtl/reg_bus_pkg.sv
// Register-bus shared definitions: FSM state encoding, frame header layout and
// the command map shared with every register slave.
package reg_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    WR_DATA,
    RD_FETCH,
    RD_SEND
  } state_t;

  localparam int HDR_RD_BIT  = 7;
  localparam int HDR_CMD_MSB = 6;
  localparam int HDR_CMD_LSB = 0;

  localparam logic [7:0] CMD_DIGITAL_EDGE_DETECTOR_CFG = 8'd49;

  function automatic logic [7:0] hdr_cmd(input logic [7:0] hdr);
    return {1'b0, hdr[HDR_CMD_MSB:HDR_CMD_LSB]};
  endfunction

endpackage

// File: rtl/reg_bus_timeout.sv
// Inter-byte watchdog: counts idle cycles, restarts on clear, and flags expiry
// once LIMIT cycles have passed. Saturates so the flag stays up until cleared.
module reg_bus_timeout #(
  parameter logic [23:0] LIMIT = 24'd12_000_000
) (
  input  logic clk_usb,
  input  logic reset_n,
  input  logic clear,
  output logic expired
);

  logic [23:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 24'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/reg_bus_master.sv
// Register-bus initiator: parses header/length/payload frames from the serial
// receiver into register strobes and streams read data back to the transmitter.
// Optional inter-byte timeout is enabled with `define REG_BUS_TIMEOUT_EN.
module reg_bus_master #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic        clk_usb,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  reg_cmd,
  output logic [15:0] reg_bytecount,
  output logic [7:0]  reg_data_in,
  input  logic [7:0]  reg_data_out,
  output logic        reg_read,
  output logic        reg_write
);

  import reg_bus_pkg::*;

  state_t      state;
  logic        hdr_rd;
  logic [7:0]  cmd;
  logic [15:0] len;
  logic [15:0] idx;
  logic        last_idx;
  logic        timeout_expired;

  assign last_idx = (idx == len - 16'd1);

`ifdef REG_BUS_TIMEOUT_EN
  logic timeout_clear;

  // Only the byte-gathering states are watched; reads wait on the transmitter.
  assign timeout_clear = rx_valid || !(state inside {LEN_LO, LEN_HI, WR_DATA});

  reg_bus_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_usb(clk_usb),
    .reset_n(reset_n),
    .clear  (timeout_clear),
    .expired(timeout_expired)
  );
`else
  logic unused_timeout;

  assign unused_timeout  = ^TIMEOUT_CYCLES;
  assign timeout_expired = 1'b0;
`endif

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      hdr_rd        <= 1'b0;
      cmd           <= '0;
      len           <= '0;
      idx           <= '0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      reg_cmd       <= '0;
      reg_bytecount <= '0;
      reg_data_in   <= '0;
      reg_read      <= 1'b0;
      reg_write     <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle; a branch that fires raises them for one cycle only.
      reg_read  <= 1'b0;
      reg_write <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_valid) begin
            hdr_rd <= rx_data[HDR_RD_BIT];
            cmd    <= hdr_cmd(rx_data);
            state  <= LEN_LO;
          end
        end

        LEN_LO: begin
          if (rx_valid) begin
            len[7:0] <= rx_data;
            state    <= LEN_HI;
          end else if (timeout_expired) begin
            state <= IDLE;
          end
        end

        LEN_HI: begin
          if (rx_valid) begin
            len[15:8] <= rx_data;
            idx       <= '0;
            if ({rx_data, len[7:0]} == 16'd0) begin
              state <= IDLE;
            end else if (hdr_rd) begin
              // The first fetch strobe is raised on entry so it coincides with RD_FETCH.
              reg_read      <= 1'b1;
              reg_bytecount <= '0;
              reg_cmd       <= cmd;
              state         <= RD_FETCH;
            end else begin
              state <= WR_DATA;
            end
          end else if (timeout_expired) begin
            state <= IDLE;
          end
        end

        WR_DATA: begin
          if (rx_valid) begin
            reg_write     <= 1'b1;
            reg_data_in   <= rx_data;
            reg_bytecount <= idx;
            reg_cmd       <= cmd;
            idx           <= idx + 16'd1;
            if (last_idx) begin
              state <= IDLE;
            end
          end else if (timeout_expired) begin
            state <= IDLE;
          end
        end

        RD_FETCH: begin
          tx_data  <= reg_data_out;
          tx_valid <= 1'b1;
          state    <= RD_SEND;
        end

        RD_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (last_idx) begin
              state <= IDLE;
            end else begin
              idx           <= idx + 16'd1;
              reg_read      <= 1'b1;
              reg_bytecount <= idx + 16'd1;
              reg_cmd       <= cmd;
              state         <= RD_FETCH;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: directed frames from the test plan plus randomized
// frames, checked against a frame-level model of the register transactions.
module tb_reg_bus_master;

  localparam logic [23:0] TO_CYCLES = 24'd100;

  logic        clk_usb;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  reg_cmd;
  logic [15:0] reg_bytecount;
  logic [7:0]  reg_data_in;
  logic [7:0]  reg_data_out;
  logic        reg_read;
  logic        reg_write;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] bc;
    logic [7:0]  data;
  } ev_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_sent_cyc = 0;
  int ready_mode = 0;
  int stall_cnt = 0;

  logic [7:0] slave_mem [256];
  logic [7:0] pl [$];
  ev_t        obs_wr [$];
  ev_t        obs_rd [$];
  logic [7:0] obs_tx [$];
  int         obs_wr_cyc [$];
  ev_t        exp_wr [$];
  ev_t        exp_rd [$];
  logic [7:0] exp_tx [$];
  int         exp_wr_cyc [$];

  reg_bus_master #(
    .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .clk_usb      (clk_usb),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .reg_cmd      (reg_cmd),
    .reg_bytecount(reg_bytecount),
    .reg_data_in  (reg_data_in),
    .reg_data_out (reg_data_out),
    .reg_read     (reg_read),
    .reg_write    (reg_write)
  );

  // Slave returns its memory only while it is being read, like one leg of the ORed bus.
  assign reg_data_out = reg_read ? slave_mem[reg_bytecount[7:0]] : 8'h00;

  initial begin
    clk_usb = 1'b0;
    forever #5 clk_usb = ~clk_usb;
  end

  always @(posedge clk_usb) cyc <= cyc + 1;

  // Transmitter: 0 = always ready, 1 = three stall cycles per byte, 2 = random.
  initial begin
    forever begin
      @(posedge clk_usb);
      #1;
      if (!tx_valid) stall_cnt = 0;
      else           stall_cnt++;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = tx_valid && (stall_cnt > 3);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Bus monitor, sampled mid-cycle.
  logic        prev_read = 1'b0;
  logic        prev_write = 1'b0;
  logic        prev_txv = 1'b0;
  logic        prev_hs = 1'b0;
  logic [15:0] prev_bc = '0;
  logic [7:0]  prev_tx = '0;

  always @(negedge clk_usb) begin
    ev_t e;
    if (reset_n) begin
      e.cmd  = reg_cmd;
      e.bc   = reg_bytecount;
      e.data = reg_data_in;
      if (reg_write) begin
        obs_wr.push_back(e);
        obs_wr_cyc.push_back(cyc);
      end
      if (reg_read) begin
        e.data = 8'h00;
        obs_rd.push_back(e);
      end
      if (tx_valid && tx_ready) obs_tx.push_back(tx_data);
      if (reg_read || reg_write) begin
        n_checks++;
        if ((reg_read && reg_write) || (prev_write && reg_write && prev_bc == reg_bytecount)
            || (prev_read && reg_read)) begin
          n_errors++;
          $display("FAIL strobe_rules: read=%b write=%b prev_read=%b prev_write=%b bc=%0d",
                   reg_read, reg_write, prev_read, prev_write, reg_bytecount);
        end
      end
      if (prev_read) begin
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== slave_mem[prev_bc[7:0]]) begin
          n_errors++;
          $display("FAIL read_latency: tx_valid=%b tx_data=%h, expected 1 and %h",
                   tx_valid, tx_data, slave_mem[prev_bc[7:0]]);
        end
      end
      if (prev_txv && !prev_hs) begin
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_tx) begin
          n_errors++;
          $display("FAIL tx_hold: tx_valid=%b tx_data=%h, expected 1 and %h", tx_valid, tx_data, prev_tx);
        end
      end
      prev_read  = reg_read;
      prev_write = reg_write;
      prev_bc    = reg_bytecount;
      prev_txv   = tx_valid;
      prev_hs    = tx_valid && tx_ready;
      prev_tx    = tx_data;
    end else begin
      prev_read  = 1'b0;
      prev_write = 1'b0;
      prev_txv   = 1'b0;
      prev_hs    = 1'b0;
    end
  end

  // ---------------- stimulus and model ----------------

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_usb);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data       = b;
    rx_valid      = 1'b1;
    last_sent_cyc = cyc;
    @(posedge clk_usb);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic clear_q();
    obs_wr.delete(); obs_rd.delete(); obs_tx.delete(); obs_wr_cyc.delete();
    exp_wr.delete(); exp_rd.delete(); exp_tx.delete(); exp_wr_cyc.delete();
  endtask

  task automatic fill_pl(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  // Expected transactions of one complete frame: one strobe per byte, index from 0.
  task automatic model_frame(input logic [7:0] hdr, input logic [15:0] len);
    ev_t e;
    for (int i = 0; i < int'(len); i++) begin
      e.cmd = {1'b0, hdr[6:0]};
      e.bc  = 16'(i);
      if (hdr[7]) begin
        e.data = 8'h00;
        exp_rd.push_back(e);
        exp_tx.push_back(slave_mem[e.bc[7:0]]);
      end else begin
        e.data = pl[i];
        exp_wr.push_back(e);
      end
    end
  endtask

  task automatic wait_tx();
    int budget = 3000;
    while (obs_tx.size() < exp_tx.size() && budget > 0) begin
      @(posedge clk_usb);
      #1;
      budget--;
    end
    n_checks++;
    if (budget == 0) begin
      n_errors++;
      $display("FAIL tx_wait: got %0d bytes, expected %0d", obs_tx.size(), exp_tx.size());
    end
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [15:0] len, input int max_gap);
    model_frame(hdr, len);
    send_byte(hdr);
    if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    if (!hdr[7]) begin
      for (int i = 0; i < int'(len); i++) begin
        if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
        send_byte(pl[i]);
        exp_wr_cyc.push_back(last_sent_cyc + 1);
      end
    end else if (len != 16'd0) begin
      wait_tx();
    end
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    idle(2);
    n_checks++;
    if ({tx_data, tx_valid, reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write} !== 43'd0) begin
      n_errors++;
      $display("FAIL reset_hold: outputs %h, expected 0",
               {tx_data, tx_valid, reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write});
    end
    reset_n = 1'b1;
    idle(2);
    n_checks++;
    if ({tx_data, tx_valid, reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write} !== 43'd0) begin
      n_errors++;
      $display("FAIL reset_release: outputs %h, expected 0",
               {tx_data, tx_valid, reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write});
    end
  endtask

  task automatic test_single_write();
    clear_q();
    ready_mode = 0;
    pl.delete();
    pl.push_back(8'hA5);
    send_frame(8'h31, 16'd1, 0);
    idle(3);
    n_checks++;
    if (obs_wr.size() != 1 || obs_wr_cyc.size() != 1) begin
      n_errors++;
      $display("FAIL single_write_count: got %0d, expected 1", obs_wr.size());
    end else begin
      n_checks++;
      if (obs_wr[0] !== {8'd49, 16'd0, 8'hA5} || obs_wr[0] !== exp_wr[0]) begin
        n_errors++;
        $display("FAIL single_write_data: got %h, expected %h", obs_wr[0], {8'd49, 16'd0, 8'hA5});
      end
      n_checks++;
      if (obs_wr_cyc[0] != exp_wr_cyc[0]) begin
        n_errors++;
        $display("FAIL single_write_latency: got cycle %0d, expected %0d", obs_wr_cyc[0], exp_wr_cyc[0]);
      end
    end
  endtask

  task automatic test_read_stall();
    clear_q();
    ready_mode   = 1;
    slave_mem[0] = 8'h3C;
    slave_mem[1] = 8'h5A;
    send_frame(8'hB1, 16'd2, 0);
    idle(3);
    n_checks++;
    if (obs_rd.size() != 2 || obs_tx.size() != 2) begin
      n_errors++;
      $display("FAIL read_stall_count: got %0d reads %0d bytes, expected 2 and 2", obs_rd.size(), obs_tx.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs_rd[i] !== exp_rd[i] || obs_tx[i] !== exp_tx[i]) begin
          n_errors++;
          $display("FAIL read_stall[%0d]: got %h/%h, expected %h/%h", i, obs_rd[i], obs_tx[i], exp_rd[i], exp_tx[i]);
        end
      end
      n_checks++;
      if (obs_tx[0] !== 8'h3C || obs_tx[1] !== 8'h5A) begin
        n_errors++;
        $display("FAIL read_stall_bytes: got %h %h, expected 3c 5a", obs_tx[0], obs_tx[1]);
      end
    end
    n_checks++;
    if (obs_wr.size() != 0) begin
      n_errors++;
      $display("FAIL read_stall_writes: got %0d writes, expected 0", obs_wr.size());
    end
  endtask

  task automatic test_rx_during_read();
    int budget = 50;
    clear_q();
    ready_mode = 1;
    model_frame(8'hB1, 16'd2);
    send_byte(8'hB1);
    send_byte(8'h02);
    send_byte(8'h00);
    while (tx_valid !== 1'b1 && budget > 0) begin
      idle(1);
      budget--;
    end
    send_byte(8'h31);
    send_byte(8'h07);
    n_checks++;
    if (budget == 0 || reg_cmd !== 8'h31) begin
      n_errors++;
      $display("FAIL rx_during_read_cmd: reg_cmd=%h budget=%0d, expected 31", reg_cmd, budget);
    end
    wait_tx();
    idle(3);
    n_checks++;
    if (obs_wr.size() != 0 || obs_tx.size() != 2 || obs_rd.size() != 2) begin
      n_errors++;
      $display("FAIL rx_during_read_count: writes %0d bytes %0d reads %0d, expected 0 2 2",
               obs_wr.size(), obs_tx.size(), obs_rd.size());
    end else if (obs_tx[1] !== exp_tx[1] || obs_rd[1] !== exp_rd[1]) begin
      n_errors++;
      $display("FAIL rx_during_read_data: got %h/%h, expected %h/%h", obs_rd[1], obs_tx[1], exp_rd[1], exp_tx[1]);
    end
  endtask

  task automatic test_zero_len();
    clear_q();
    ready_mode = 0;
    send_frame(8'h31, 16'd0, 0);
    send_frame(8'hB1, 16'd1, 0);
    idle(3);
    n_checks++;
    if (obs_wr.size() != 0 || obs_rd.size() != 1 || obs_tx.size() != 1) begin
      n_errors++;
      $display("FAIL zero_len_count: writes %0d reads %0d bytes %0d, expected 0 1 1",
               obs_wr.size(), obs_rd.size(), obs_tx.size());
    end else begin
      n_checks++;
      if (obs_rd[0] !== exp_rd[0] || obs_tx[0] !== exp_tx[0]) begin
        n_errors++;
        $display("FAIL zero_len_next: got %h/%h, expected %h/%h", obs_rd[0], obs_tx[0], exp_rd[0], exp_tx[0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    ev_t e;
    clear_q();
    ready_mode = 0;
    fill_pl(4);
    for (int i = 0; i < 2; i++) begin
      e.cmd = 8'd49; e.bc = 16'(i); e.data = pl[i];
      exp_wr.push_back(e);
    end
    send_byte(8'h31);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(pl[0]);
    send_byte(pl[1]);
    idle(2);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({tx_data, tx_valid, reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write} !== 43'd0) begin
      n_errors++;
      $display("FAIL reset_mid_frame_outputs: outputs %h, expected 0",
               {tx_data, tx_valid, reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write});
    end
    idle(2);
    reset_n = 1'b1;
    idle(1);
    pl.delete();
    pl.push_back(8'h07);
    send_frame(8'h31, 16'd1, 0);
    idle(3);
    n_checks++;
    if (obs_wr.size() != 3) begin
      n_errors++;
      $display("FAIL reset_mid_frame_count: got %0d writes, expected 3", obs_wr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_wr[i] !== exp_wr[i]) begin
          n_errors++;
          $display("FAIL reset_mid_frame[%0d]: got %h, expected %h", i, obs_wr[i], exp_wr[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    ev_t e;
    clear_q();
    ready_mode = 0;
    e.cmd = 8'd49;
`ifdef REG_BUS_TIMEOUT_EN
    e.bc = 16'd0; e.data = 8'h11; exp_wr.push_back(e);
`else
    // The stale header stands, so 31 01 becomes a 0x0131-byte length and the frame stays open.
    e.bc = 16'd0; e.data = 8'h00; exp_wr.push_back(e);
    e.bc = 16'd1; e.data = 8'h11; exp_wr.push_back(e);
`endif
    send_byte(8'h31);
    idle(150);
    send_byte(8'h31);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    idle(3);
    n_checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      n_errors++;
      $display("FAIL timeout_count: got %0d writes, expected %0d", obs_wr.size(), exp_wr.size());
    end else begin
      foreach (exp_wr[i]) begin
        n_checks++;
        if (obs_wr[i] !== exp_wr[i]) begin
          n_errors++;
          $display("FAIL timeout_write[%0d]: got %h, expected %h", i, obs_wr[i], exp_wr[i]);
        end
      end
    end
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_back_to_back();
    clear_q();
    ready_mode = 0;
    for (int f = 0; f < 3; f++) begin
      fill_pl(int'($urandom_range(1, 5)));
      send_frame({1'b0, 7'($urandom)}, 16'(pl.size()), 0);
    end
    idle(3);
    n_checks++;
    if (obs_wr.size() != exp_wr.size() || obs_wr_cyc.size() != exp_wr_cyc.size()) begin
      n_errors++;
      $display("FAIL back_to_back_count: got %0d writes, expected %0d", obs_wr.size(), exp_wr.size());
    end else begin
      foreach (exp_wr[i]) begin
        n_checks++;
        if (obs_wr[i] !== exp_wr[i] || obs_wr_cyc[i] != exp_wr_cyc[i]) begin
          n_errors++;
          $display("FAIL back_to_back[%0d]: got %h at cycle %0d, expected %h at cycle %0d",
                   i, obs_wr[i], obs_wr_cyc[i], exp_wr[i], exp_wr_cyc[i]);
        end
      end
    end
  endtask

  task automatic test_random_frames();
    logic [7:0]  hdr;
    logic [15:0] len;
    clear_q();
    ready_mode = 2;
    for (int i = 0; i < 256; i++) slave_mem[i] = 8'($urandom);
    for (int f = 0; f < 40; f++) begin
      hdr = 8'($urandom);
      len = 16'($urandom_range(0, 6));
      if (f == 7) begin
        hdr[7] = 1'b0;
        len    = 16'd300;
      end
      fill_pl(int'(len));
      send_frame(hdr, len, 2);
    end
    idle(3);
    n_checks++;
    if (obs_wr.size() != exp_wr.size() || obs_rd.size() != exp_rd.size() || obs_tx.size() != exp_tx.size()) begin
      n_errors++;
      $display("FAIL random_count: writes %0d/%0d reads %0d/%0d bytes %0d/%0d (got/expected)",
               obs_wr.size(), exp_wr.size(), obs_rd.size(), exp_rd.size(), obs_tx.size(), exp_tx.size());
    end else begin
      foreach (exp_wr[i]) begin
        n_checks++;
        if (obs_wr[i] !== exp_wr[i]) begin
          n_errors++;
          $display("FAIL random_write[%0d]: got %h, expected %h", i, obs_wr[i], exp_wr[i]);
        end
      end
      foreach (exp_rd[i]) begin
        n_checks++;
        if (obs_rd[i] !== exp_rd[i] || obs_tx[i] !== exp_tx[i]) begin
          n_errors++;
          $display("FAIL random_read[%0d]: got %h/%h, expected %h/%h", i, obs_rd[i], obs_tx[i], exp_rd[i], exp_tx[i]);
        end
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    for (int i = 0; i < 256; i++) slave_mem[i] = 8'h00;
    test_reset();
    test_single_write();
    test_read_stall();
    test_rx_during_read();
    test_zero_len();
    test_reset_mid_frame();
    test_timeout();
    test_back_to_back();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
